// File: rtl/apb2axi_write_response.sv
// AXI write-response tracker: per-TAG outstanding bitmap plus a 2-entry completion FIFO.
// Optional saturating SLVERR/DECERR counter enabled by macro APB2AXI_BRESP_ERR_CNT_EN.
module apb2axi_write_response #(
   parameter int TAG_NUM  = 4,
   parameter int AXI_ID_W = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                aw_fire,
   input  logic [AXI_ID_W-1:0] aw_fire_id,
   input  logic [AXI_ID_W-1:0] bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic                cpl_vld,
   input  logic                cpl_rdy,
   output logic [AXI_ID_W-1:0] cpl_tag,
   output logic [1:0]          cpl_resp,
   output logic [TAG_NUM-1:0]  outstanding,
   output logic                unexp_b_err,
   output logic                dup_aw_err,
   output logic [7:0]          err_cnt
);

   logic [TAG_NUM-1:0]  outstanding_reg;
   logic [TAG_NUM-1:0]  outstanding_next;
   logic [TAG_NUM-1:0]  b_match;
   logic [TAG_NUM-1:0]  aw_match;
   logic                bready_reg;
   logic                unexp_reg;
   logic                dup_reg;
   logic                wr_ptr_reg;
   logic                rd_ptr_reg;
   logic [1:0]          count_reg;
   logic [1:0]          count_next;
   logic [AXI_ID_W-1:0] tag_mem [2];
   logic [1:0]          resp_mem [2];

   logic b_hs;
   logic b_hit;
   logic aw_free;
   logic aw_rearm;
   logic push;
   logic pop;

   assign b_hs = bvalid && bready_reg;

   // Out-of-range IDs match no TAG, so they naturally fall into the error paths.
   genvar gi;
   generate
      for (gi = 0; gi < TAG_NUM; gi++) begin : g_tag
         assign b_match[gi]  = b_hs && (bid == AXI_ID_W'(gi));
         assign aw_match[gi] = aw_fire && (aw_fire_id == AXI_ID_W'(gi));
      end
   endgenerate

   assign b_hit    = |(b_match & outstanding_reg);
   assign aw_free  = |(aw_match & ~outstanding_reg);
   assign aw_rearm = |(aw_match & b_match & outstanding_reg);
   assign push     = b_hit;
   assign pop      = cpl_rdy && (count_reg != 2'd0);

   // Clear for completed TAGs first, then set for new AWs so a same-cycle re-arm wins.
   assign outstanding_next = (outstanding_reg & ~b_match) | aw_match;

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + 2'd1;
      end else if (pop && !push) begin
         count_next = count_reg - 2'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         outstanding_reg <= '0;
         bready_reg      <= 1'b0;
         unexp_reg       <= 1'b0;
         dup_reg         <= 1'b0;
         wr_ptr_reg      <= 1'b0;
         rd_ptr_reg      <= 1'b0;
         count_reg       <= 2'd0;
      end else begin
         outstanding_reg <= outstanding_next;
         bready_reg      <= (count_next != 2'd2);
         unexp_reg       <= b_hs && !b_hit;
         dup_reg         <= aw_fire && !aw_free && !aw_rearm;
         count_reg       <= count_next;
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   // Storage needs no reset: reads are masked by cpl_vld.
   always_ff @(posedge aclk) begin
      if (push) begin
         tag_mem[wr_ptr_reg]  <= bid;
         resp_mem[wr_ptr_reg] <= bresp;
      end
   end

   assign bready      = bready_reg;
   assign cpl_vld     = (count_reg != 2'd0);
   assign cpl_tag     = cpl_vld ? tag_mem[rd_ptr_reg] : '0;
   assign cpl_resp    = cpl_vld ? resp_mem[rd_ptr_reg] : 2'b00;
   assign outstanding = outstanding_reg;
   assign unexp_b_err = unexp_reg;
   assign dup_aw_err  = dup_reg;

`ifdef APB2AXI_BRESP_ERR_CNT_EN
   logic [7:0] err_cnt_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_cnt_reg <= 8'd0;
      end else if (push && bresp[1] && (err_cnt_reg != 8'hFF)) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign err_cnt = err_cnt_reg;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_apb2axi_write_response.sv
// Randomized + directed bench for apb2axi_write_response against a queue-based reference model.
// Honours APB2AXI_BRESP_ERR_CNT_EN the same way the design does.
module tb_apb2axi_write_response;

   localparam int TAG_NUM  = 4;
   localparam int AXI_ID_W = 4;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic                aw_fire = 1'b0;
   logic [AXI_ID_W-1:0] aw_fire_id = '0;
   logic [AXI_ID_W-1:0] bid = '0;
   logic [1:0]          bresp = 2'b00;
   logic                bvalid = 1'b0;
   logic                bready;
   logic                cpl_vld;
   logic                cpl_rdy = 1'b0;
   logic [AXI_ID_W-1:0] cpl_tag;
   logic [1:0]          cpl_resp;
   logic [TAG_NUM-1:0]  outstanding;
   logic                unexp_b_err;
   logic                dup_aw_err;
   logic [7:0]          err_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [TAG_NUM-1:0] m_out;
   int                 q_tag[$];
   int                 q_resp[$];
   bit                 m_bready;
   bit                 m_unexp;
   bit                 m_dup;
   int                 m_err;

   always #5 aclk = ~aclk;

   apb2axi_write_response #(.TAG_NUM(TAG_NUM), .AXI_ID_W(AXI_ID_W)) dut (
      .aclk(aclk), .aresetn(aresetn), .aw_fire(aw_fire), .aw_fire_id(aw_fire_id),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .cpl_vld(cpl_vld), .cpl_rdy(cpl_rdy), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp),
      .outstanding(outstanding), .unexp_b_err(unexp_b_err), .dup_aw_err(dup_aw_err),
      .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out    = '0;
      q_tag.delete();
      q_resp.delete();
      m_bready = 0;
      m_unexp  = 0;
      m_dup    = 0;
      m_err    = 0;
   endtask

   // Applies the spec rules for one clock edge using the inputs presented at that edge.
   task automatic model_edge();
      bit                 hs;
      bit                 b_ok;
      int                 b;
      int                 a;
      logic [TAG_NUM-1:0] nxt;
      b    = int'(bid);
      a    = int'(aw_fire_id);
      hs   = bvalid && m_bready;
      b_ok = hs && (b < TAG_NUM) && m_out[b];
      nxt  = m_out;
      m_unexp = hs && !b_ok;
      m_dup   = 0;
      if (b_ok) nxt[b] = 1'b0;
      if (aw_fire) begin
         if (a >= TAG_NUM) m_dup = 1;
         else if (!m_out[a]) nxt[a] = 1'b1;
         else if (b_ok && b == a) nxt[a] = 1'b1;
         else m_dup = 1;
      end
      m_out = nxt;
      if (cpl_rdy && q_tag.size() > 0) begin
         void'(q_tag.pop_front());
         void'(q_resp.pop_front());
      end
      if (b_ok) begin
         q_tag.push_back(b);
         q_resp.push_back(int'(bresp));
`ifdef APB2AXI_BRESP_ERR_CNT_EN
         if (bresp[1] && m_err < 255) m_err++;
`endif
      end
      m_bready = (q_tag.size() != 2);
   endtask

   task automatic check_all();
      chk("bready", 32'(bready), 32'(m_bready));
      chk("cpl_vld", 32'(cpl_vld), 32'(q_tag.size() != 0));
      chk("cpl_tag", 32'(cpl_tag), (q_tag.size() != 0) ? q_tag[0] : 0);
      chk("cpl_resp", 32'(cpl_resp), (q_resp.size() != 0) ? q_resp[0] : 0);
      chk("outstanding", 32'(outstanding), 32'(m_out));
      chk("unexp_b_err", 32'(unexp_b_err), 32'(m_unexp));
      chk("dup_aw_err", 32'(dup_aw_err), 32'(m_dup));
      chk("err_cnt", 32'(err_cnt), m_err);
   endtask

   task automatic step(input bit aw, input int awid, input bit bv, input int b,
                       input int br, input bit rdy, input bit verbose);
      @(negedge aclk);
      aw_fire    = aw;
      aw_fire_id = AXI_ID_W'(awid);
      bvalid     = bv;
      bid        = AXI_ID_W'(b);
      bresp      = 2'(br);
      cpl_rdy    = rdy;
      @(posedge aclk);
      model_edge();
      #1;
      check_all();
      if (verbose)
         $display("aw=%0b/%0d b=%0b/%0d/%0d rdy=%0b -> vld=%0b tag=%0d resp=%0d out=%b bready=%0b",
                  aw, awid, bv, b, br, rdy, cpl_vld, cpl_tag, cpl_resp, outstanding, bready);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy, 1);
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_bready"}, 32'(bready), 0);
      chk({pfx, "_cpl_vld"}, 32'(cpl_vld), 0);
      chk({pfx, "_cpl_tag"}, 32'(cpl_tag), 0);
      chk({pfx, "_cpl_resp"}, 32'(cpl_resp), 0);
      chk({pfx, "_outstanding"}, 32'(outstanding), 0);
      chk({pfx, "_unexp"}, 32'(unexp_b_err), 0);
      chk({pfx, "_dup"}, 32'(dup_aw_err), 0);
      chk({pfx, "_err_cnt"}, 32'(err_cnt), 0);
   endtask

   initial begin
      int aw_id;
      int b_id;
      model_reset();
      #12;
      check_zero("reset");
      @(negedge aclk);
      aresetn = 1'b1;
      idle(1, 0);
      chk("bready_after_release", 32'(bready), 1);

      // single AW / B round trip with one-cycle latency
      step(1, 2, 0, 0, 0, 0, 1);
      chk("out2_set", 32'(outstanding[2]), 1);
      step(0, 0, 1, 2, 0, 0, 1);
      chk("lat_vld", 32'(cpl_vld), 1);
      chk("lat_tag", 32'(cpl_tag), 2);
      chk("out2_clr", 32'(outstanding[2]), 0);
      idle(1, 1);

      // out-of-order completions with back-pressure
      step(1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 1);
      step(1, 2, 0, 0, 0, 0, 1);
      step(0, 0, 1, 1, 1, 0, 1);
      step(0, 0, 1, 0, 3, 0, 1);
      step(0, 0, 1, 2, 0, 0, 1);
      chk("full_bready", 32'(bready), 0);
      chk("full_head", 32'(cpl_tag), 1);
      step(0, 0, 1, 2, 0, 1, 1);
      chk("pop1_head", 32'(cpl_tag), 0);
      step(0, 0, 1, 2, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      idle(2, 1);

      // unexpected B
      step(0, 0, 1, 3, 0, 0, 1);
      chk("unexp_pulse", 32'(unexp_b_err), 1);
      idle(1, 0);
      chk("unexp_once", 32'(unexp_b_err), 0);

      // duplicate AW and same-cycle re-arm
      step(1, 1, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 1);
      chk("dup_pulse", 32'(dup_aw_err), 1);
      step(1, 1, 1, 1, 2, 0, 1);
      chk("rearm_tag", 32'(cpl_tag), 1);
      chk("rearm_bit", 32'(outstanding[1]), 1);
      chk("rearm_nodup", 32'(dup_aw_err), 0);
      step(1, 9, 0, 0, 0, 1, 1);
      step(1, 3, 1, 3, 0, 1, 1);
      idle(2, 1);

      // saturating error count at full throughput
      step(1, 0, 1, 1, 0, 1, 1);
      for (int i = 0; i < 300; i++) step(1, 0, 1, 0, 2, 1, 0);
`ifdef APB2AXI_BRESP_ERR_CNT_EN
      chk("err_sat", 32'(err_cnt), 255);
`else
      chk("err_off", 32'(err_cnt), 0);
`endif
      step(0, 0, 1, 0, 0, 1, 1);
      idle(2, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         aw_id = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TAG_NUM) : $urandom_range(0, 15);
         b_id  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TAG_NUM) : $urandom_range(0, 15);
         step(($urandom_range(0, 2) == 0), aw_id, ($urandom_range(0, 1) == 1), b_id,
              $urandom_range(0, 3), ($urandom_range(0, 3) != 0), (i % 100 == 0));
      end
      idle(3, 1);

      // asynchronous reset with two completions buffered and outstanding=1011
      step(1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 1);
      step(1, 2, 0, 0, 0, 0, 1);
      step(1, 3, 0, 0, 0, 0, 1);
      step(0, 0, 1, 2, 0, 0, 1);
      step(1, 2, 0, 0, 0, 0, 1);
      step(0, 0, 1, 2, 2, 0, 1);
      chk("pre_rst_out", 32'(outstanding), 32'hB);
      chk("pre_rst_vld", 32'(cpl_vld), 1);
      @(negedge aclk);
      #2;
      aresetn = 1'b0;
      model_reset();
      #1;
      check_zero("async_rst");
      @(negedge aclk);
      aresetn = 1'b1;
      idle(1, 0);
      chk("bready_post_rst", 32'(bready), 1);
      idle(2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb2axi_write_response.md
APB2AXI_WRITE_RESPONSE -- requirements
Module: apb2axi_write_response

Interface
REQ-001 SHALL have parameter TAG_NUM, default 4, meaning number of write TAGs tracked (one outstanding per TAG).
REQ-002 SHALL have parameter AXI_ID_W, default 4, meaning width of AXI ID and TAG fields.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 aclk  in  1  sole clock; all state on rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 aw_fire  in  1  AW handshake (awvalid && awready) seen this cycle.
REQ-007 aw_fire_id  in  AXI_ID_W  awid of that handshake.
REQ-008 bid  in  AXI_ID_W  AXI B ID.
REQ-009 bresp  in  2  AXI B response.
REQ-010 bvalid  in  1  AXI B valid.
REQ-011 bready  out  1  AXI B ready.
REQ-012 cpl_vld  out  1  completion available at FIFO head.
REQ-013 cpl_rdy  in  1  consumer (directory) pops completion.
REQ-014 cpl_tag  out  AXI_ID_W  TAG of head completion.
REQ-015 cpl_resp  out  2  bresp of head completion.
REQ-016 outstanding  out  TAG_NUM  per-TAG bitmap: AW issued, B not yet received.
REQ-017 unexp_b_err  out  1  one-cycle pulse: accepted B with no outstanding TAG.
REQ-018 dup_aw_err  out  1  one-cycle pulse: AW on already-outstanding TAG.
REQ-019 err_cnt  out  8  count of SLVERR/DECERR responses (see Configuration).

Function
REQ-020 Completion store SHALL be a 2-entry FIFO with wrapping 1-bit read/write pointers and a 0..2 count register.
REQ-021 bready SHALL equal (count != 2), decoded from registered state only; no combinational path from cpl_rdy.
REQ-022 B handshake = bvalid && bready; in a cycle without a B handshake, bid/bresp SHALL be ignored.
REQ-023 On B handshake with bid < TAG_NUM and outstanding[bid]=1 (pre-edge value): push {bid, bresp}, clear outstanding[bid] next edge.
REQ-024 On B handshake with bid >= TAG_NUM or outstanding[bid]=0: no push, bitmap unchanged, unexp_b_err=1 the next cycle.
REQ-025 On aw_fire with aw_fire_id < TAG_NUM and outstanding bit 0: set bit next edge.
REQ-026 On aw_fire with the bit already 1: bit stays 1, dup_aw_err=1 the next cycle; aw_fire_id >= TAG_NUM: ignored, dup_aw_err=1.
REQ-027 Same-cycle aw_fire and B handshake, same ID, bit previously 0: B is unexpected (REQ-024), bit is set by AW.
REQ-028 Same-cycle aw_fire and B handshake, same ID, bit previously 1: B completes, bit stays 1 (re-armed), no dup_aw_err.
REQ-029 cpl_vld = (count != 0); cpl_tag/cpl_resp SHALL be head entry and stay stable while cpl_vld && !cpl_rdy.
REQ-030 Simultaneous push and pop SHALL keep count; push at count 2 is impossible (bready=0); pop at count 0 SHALL be ignored.
REQ-031 Latency: B handshake at edge N -> cpl_vld=1 after edge N when FIFO was empty (1 cycle).
REQ-032 Sustained throughput SHALL be one B per cycle while cpl_rdy=1.

Reset
REQ-033 While aresetn=0: bready=0, cpl_vld=0, cpl_tag=0, cpl_resp=0, outstanding=0, unexp_b_err=0, dup_aw_err=0, err_cnt=0, pointers/count=0.
REQ-034 Reset mid-operation SHALL discard all buffered completions and outstanding state immediately (asynchronous); bready=1 the first cycle after release.

Configuration
REQ-035 Macro APB2AXI_BRESP_ERR_CNT_EN defined: err_cnt increments on each pushed completion with bresp[1]=1, saturates at 255, never wraps.
REQ-036 Macro undefined: err_cnt tied to 0, no counter logic; all other behaviour identical, port list unchanged.

Verification
REQ-037 aw_fire id=2, then B bid=2 bresp=0 -> cpl_vld next cycle, cpl_tag=2, cpl_resp=0, outstanding[2] 1->0.
REQ-038 AW ids 0,1,2; B ids 1,0,2 (out of order), cpl_rdy=0 -> bready=0 after 2 accepted; raise cpl_rdy -> pops 1,0,then 2.
REQ-039 B bid=3 with outstanding=0 -> unexp_b_err pulse once, cpl_vld stays 0, bitmap 0.
REQ-040 AW id=1 twice -> dup_aw_err pulse on second; same-cycle AW id=1 + B bid=1 while set -> cpl_tag=1, bit stays 1.
REQ-041 With APB2AXI_BRESP_ERR_CNT_EN: 300 completions bresp=2'b10 -> err_cnt=255; without macro -> err_cnt=0.
REQ-042 Assert aresetn=0 with 2 completions buffered and outstanding=4'b1011 -> all outputs 0 at once; bready=1 after release.
